// File: rtl/cafe_dispense_ctrl_pkg.sv
// Shared types and recipe tables for the coffee dispense sequencer.
// Optional rinse phase is enabled with CAFE_LIMPIEZA_EN.
package cafe_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        AGUA  = 3'd1,
        CAFE  = 3'd2,
        LECHE = 3'd3,
        CHOCO = 3'd4,
        FIN   = 3'd5,
        RINSE = 3'd6
    } fase_t;

    typedef logic [1:0] tipo_t;

    localparam int NUM_FASES = 4;

    localparam int VALV_AGUA  = 0;
    localparam int VALV_CAFE  = 1;
    localparam int VALV_LECHE = 2;
    localparam int VALV_CHOCO = 3;

    localparam int ESPRESSO_AGUA  = 3;
    localparam int ESPRESSO_CAFE  = 2;
    localparam int ESPRESSO_LECHE = 0;
    localparam int ESPRESSO_CHOCO = 0;

    localparam int AMERICANO_AGUA  = 6;
    localparam int AMERICANO_CAFE  = 2;
    localparam int AMERICANO_LECHE = 0;
    localparam int AMERICANO_CHOCO = 0;

    localparam int CAPUCHINO_AGUA  = 3;
    localparam int CAPUCHINO_CAFE  = 2;
    localparam int CAPUCHINO_LECHE = 4;
    localparam int CAPUCHINO_CHOCO = 0;

    localparam int MOCACCINO_AGUA  = 3;
    localparam int MOCACCINO_CAFE  = 2;
    localparam int MOCACCINO_LECHE = 2;
    localparam int MOCACCINO_CHOCO = 3;

    // Rows indexed by tipo, columns by phase order agua/cafe/leche/choco.
    localparam int RECETA [4][NUM_FASES] = '{
        '{ESPRESSO_AGUA,  ESPRESSO_CAFE,  ESPRESSO_LECHE,  ESPRESSO_CHOCO},
        '{AMERICANO_AGUA, AMERICANO_CAFE, AMERICANO_LECHE, AMERICANO_CHOCO},
        '{CAPUCHINO_AGUA, CAPUCHINO_CAFE, CAPUCHINO_LECHE, CAPUCHINO_CHOCO},
        '{MOCACCINO_AGUA, MOCACCINO_CAFE, MOCACCINO_LECHE, MOCACCINO_CHOCO}
    };

    function automatic fase_t fase_de_idx(input int i);
        return fase_t'(3'(i + 1));
    endfunction

endpackage

// File: rtl/cafe_dispense_ctrl_if.sv
// Handshake/status bundle between the payment/tick logic and the dispense sequencer.
interface cafe_dispense_ctrl_if #(parameter int SEG_W = 4);
    import cafe_pkg::*;

    logic             tick_1hz;
    logic             start;
    tipo_t            tipo_cafe;
    logic             cancelar;
    logic             busy;
    logic             done;
    logic             abortado;
    logic [3:0]       valvulas;
    fase_t            fase;
    logic [SEG_W-1:0] seg_restantes;

    modport master (
        output tick_1hz, start, tipo_cafe, cancelar,
        input  busy, done, abortado, valvulas, fase, seg_restantes
    );

    modport slave (
        input  tick_1hz, start, tipo_cafe, cancelar,
        output busy, done, abortado, valvulas, fase, seg_restantes
    );

endinterface

// File: rtl/cafe_dispense_ctrl_receta_rom.sv
// Combinational recipe lookup: (coffee type, phase) -> phase duration in seconds.
module cafe_receta_rom
    import cafe_pkg::*;
#(
    parameter int SEG_W = 4
) (
    input  tipo_t            tipo_i,
    input  fase_t            fase_i,
    output logic [SEG_W-1:0] dur_o
);

    always_comb begin
        dur_o = '0;
        case (fase_i)
            AGUA:    dur_o = SEG_W'(RECETA[tipo_i][0]);
            CAFE:    dur_o = SEG_W'(RECETA[tipo_i][1]);
            LECHE:   dur_o = SEG_W'(RECETA[tipo_i][2]);
            CHOCO:   dur_o = SEG_W'(RECETA[tipo_i][3]);
            default: dur_o = '0;
        endcase
    end

endmodule

// File: rtl/cafe_dispense_ctrl.sv
// Dispense sequencer: walks agua/cafe/leche/choco valves on a 1 Hz tick, with cancel.
// Define CAFE_LIMPIEZA_EN to append a rinse phase (valve agua, RINSE_SEG ticks) before FIN.
module cafe_dispense_ctrl
    import cafe_pkg::*;
#(
    parameter int SEG_W = 4
`ifdef CAFE_LIMPIEZA_EN
    ,
    parameter int RINSE_SEG = 2
`endif
) (
    input logic                  clockFPGA,
    input logic                  reset,
    cafe_dispense_ctrl_if.slave  bus
);

    fase_t            st_q, st_d;
    tipo_t            tipo_q, tipo_d;
    logic [SEG_W-1:0] cnt_q, cnt_d;
    logic [3:0]       valv_q, valv_d;
    logic             abort_q, abort_d;

    tipo_t                             tipo_sel;
    logic [NUM_FASES-1:0][SEG_W-1:0]   dur;
    int                                cur;
    fase_t                             nxt_fase;
    logic [SEG_W-1:0]                  nxt_dur;

    // In IDLE the recipe is looked up from the incoming type so the first phase loads directly.
    assign tipo_sel = (st_q == IDLE) ? bus.tipo_cafe : tipo_q;

    for (genvar g = 0; g < NUM_FASES; g++) begin : g_rom
        cafe_receta_rom #(.SEG_W(SEG_W)) u_rom (
            .tipo_i (tipo_sel),
            .fase_i (fase_de_idx(g)),
            .dur_o  (dur[g])
        );
    end

    always_comb begin
        cur = -1;
        if (st_q inside {AGUA, CAFE, LECHE, CHOCO}) cur = int'(st_q) - 1;
    end

    // First later phase with a nonzero duration; falls back to rinse/FIN.
    always_comb begin
        nxt_fase = FIN;
        nxt_dur  = '0;
`ifdef CAFE_LIMPIEZA_EN
        if (RINSE_SEG > 0) begin
            nxt_fase = RINSE;
            nxt_dur  = SEG_W'(RINSE_SEG);
        end
`endif
        for (int j = NUM_FASES - 1; j >= 0; j--) begin
            if (j > cur && dur[j] != '0) begin
                nxt_fase = fase_de_idx(j);
                nxt_dur  = dur[j];
            end
        end
    end

    always_comb begin
        st_d    = st_q;
        tipo_d  = tipo_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (bus.start && !bus.cancelar) begin
                    tipo_d = bus.tipo_cafe;
                    st_d   = nxt_fase;
                    cnt_d  = nxt_dur;
                end
            end
            AGUA, CAFE, LECHE, CHOCO: begin
                if (bus.cancelar) begin
                    st_d    = IDLE;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (bus.tick_1hz) begin
                    if (cnt_q > SEG_W'(1)) begin
                        cnt_d = cnt_q - SEG_W'(1);
                    end else begin
                        st_d  = nxt_fase;
                        cnt_d = nxt_dur;
                    end
                end
            end
`ifdef CAFE_LIMPIEZA_EN
            RINSE: begin
                if (bus.cancelar) begin
                    st_d    = IDLE;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (bus.tick_1hz) begin
                    if (cnt_q > SEG_W'(1)) begin
                        cnt_d = cnt_q - SEG_W'(1);
                    end else begin
                        st_d  = FIN;
                        cnt_d = '0;
                    end
                end
            end
`endif
            FIN: begin
                st_d  = IDLE;
                cnt_d = '0;
            end
            default: begin
                st_d  = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // Valves are decoded from the next state so they change on the same edge as the FSM.
    always_comb begin
        valv_d = '0;
        case (st_d)
            AGUA:    valv_d[VALV_AGUA]  = 1'b1;
            CAFE:    valv_d[VALV_CAFE]  = 1'b1;
            LECHE:   valv_d[VALV_LECHE] = 1'b1;
            CHOCO:   valv_d[VALV_CHOCO] = 1'b1;
`ifdef CAFE_LIMPIEZA_EN
            RINSE:   valv_d[VALV_AGUA]  = 1'b1;
`endif
            default: valv_d = '0;
        endcase
    end

    always_ff @(posedge clockFPGA or negedge reset) begin
        if (!reset) begin
            st_q    <= IDLE;
            tipo_q  <= '0;
            cnt_q   <= '0;
            valv_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            tipo_q  <= tipo_d;
            cnt_q   <= cnt_d;
            valv_q  <= valv_d;
            abort_q <= abort_d;
        end
    end

    assign bus.busy          = (st_q != IDLE);
    assign bus.done          = (st_q == FIN);
    assign bus.abortado      = abort_q;
    assign bus.valvulas      = valv_q;
    assign bus.fase          = st_q;
    assign bus.seg_restantes = (st_q == IDLE || st_q == FIN) ? '0 : cnt_q;

endmodule

// File: tb/tb_cafe_dispense_ctrl.sv
// Random + directed bench for cafe_dispense_ctrl against a segment-queue brew model.
module tb_cafe_dispense_ctrl;
    import cafe_pkg::*;

    localparam int SEG_W     = 4;
    localparam int RINSE_TB  = 2;

    logic clk;
    logic rst_n;

    cafe_dispense_ctrl_if #(.SEG_W(SEG_W)) bus ();

`ifdef CAFE_LIMPIEZA_EN
    cafe_dispense_ctrl #(.SEG_W(SEG_W), .RINSE_SEG(RINSE_TB)) dut (
        .clockFPGA (clk),
        .reset     (rst_n),
        .bus       (bus)
    );
`else
    cafe_dispense_ctrl #(.SEG_W(SEG_W)) dut (
        .clockFPGA (clk),
        .reset     (rst_n),
        .bus       (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A brew is a queue of (state code, valve bit, seconds) segments with zero-length ones dropped.
    typedef struct {
        int fase;
        int valve;
        int dur;
    } seg_t;

    int   rec [4][4] = '{'{3, 2, 0, 0}, '{6, 2, 0, 0}, '{3, 2, 4, 0}, '{3, 2, 2, 3}};
    seg_t plan[$];
    int   m_rem;
    bit   m_run, m_fin, m_abort;

    task automatic model_reset();
        plan.delete();
        m_rem = 0; m_run = 0; m_fin = 0; m_abort = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input int ty, input bit c);
        seg_t sg;
        m_abort = 0;
        if (m_fin) begin
            m_fin = 0;
        end else if (m_run) begin
            if (c) begin
                m_run = 0;
                plan.delete();
                m_abort = 1;
            end else if (t) begin
                if (m_rem > 1) m_rem--;
                else begin
                    void'(plan.pop_front());
                    if (plan.size() == 0) begin
                        m_run = 0;
                        m_fin = 1;
                    end else m_rem = plan[0].dur;
                end
            end
        end else if (s && !c) begin
            plan.delete();
            for (int p = 0; p < 4; p++) begin
                if (rec[ty][p] != 0) begin
                    sg.fase = p + 1; sg.valve = p; sg.dur = rec[ty][p];
                    plan.push_back(sg);
                end
            end
`ifdef CAFE_LIMPIEZA_EN
            sg.fase = 6; sg.valve = 0; sg.dur = RINSE_TB;
            plan.push_back(sg);
`endif
            m_run = 1;
            m_rem = plan[0].dur;
        end
    endtask

    task automatic check_outputs(input string ctx);
        int ev, ef;
        ev = m_run ? (1 << plan[0].valve) : 0;
        ef = m_run ? plan[0].fase : (m_fin ? 5 : 0);
        chk({ctx, ".valvulas"}, bus.valvulas, ev);
        chk({ctx, ".fase"}, bus.fase, ef);
        chk({ctx, ".busy"}, bus.busy, (m_run || m_fin) ? 1 : 0);
        chk({ctx, ".done"}, bus.done, m_fin ? 1 : 0);
        chk({ctx, ".abortado"}, bus.abortado, m_abort ? 1 : 0);
        chk({ctx, ".seg"}, bus.seg_restantes, m_run ? m_rem : 0);
        chk({ctx, ".onehot"}, ($countones(bus.valvulas) <= 1) ? 1 : 0, 1);
    endtask

    // Called at a negedge: drive inputs, let the posedge happen, check at the next negedge.
    task automatic step(input string ctx, input bit t, input bit s, input int ty, input bit c);
        bus.tick_1hz  = t;
        bus.start     = s;
        bus.tipo_cafe = tipo_t'(ty);
        bus.cancelar  = c;
        model_step(t, s, ty, c);
        @(negedge clk);
        check_outputs(ctx);
    endtask

    task automatic run_ticks(input string ctx, input int n);
        for (int i = 0; i < n; i++) begin
            step(ctx, 0, 0, 0, 0);
            step(ctx, 1, 0, 0, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tick_1hz = 0; bus.start = 0; bus.tipo_cafe = '0; bus.cancelar = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // espresso, start coincident with a tick
        step("esp.start", 1, 1, 0, 0);
        run_ticks("esp", 10);

        // mocaccino: all four phases
        step("moc.start", 0, 1, 3, 0);
        run_ticks("moc", 12);

        // capuchino cancelled on the 2nd leche tick
        step("cap.start", 0, 1, 2, 0);
        run_ticks("cap", 6);
        step("cap.cancel", 1, 0, 0, 1);
        step("cap.after", 0, 0, 0, 0);
        step("cap.after", 0, 0, 0, 0);

        // second start during a brew is ignored
        step("cap2.start", 0, 1, 2, 0);
        run_ticks("cap2", 3);
        step("cap2.restart", 0, 1, 1, 0);
        run_ticks("cap2", 8);

        // start together with cancel in IDLE
        step("idle.sc", 0, 1, 1, 1);
        step("idle.sc", 0, 0, 0, 0);

        // async reset while in cafe
        step("rst.start", 0, 1, 0, 0);
        run_ticks("rst", 4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async.valvulas", bus.valvulas, 0);
        chk("async.fase", bus.fase, 0);
        chk("async.busy", bus.busy, 0);
        chk("async.seg", bus.seg_restantes, 0);
        @(negedge clk);
        check_outputs("rst.held");
        rst_n = 1'b1;
        step("rst.idle", 1, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            step("rnd",
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cafe_dispense_ctrl.md
Name: cafe_dispense_ctrl

Overview:
Sequencing controller for the coffee machine's dispense stage. Once payment is verified, it accepts a start request with a coffee type and drives the ingredient valves one phase at a time: water, coffee, milk, then chocolate. Each phase lasts a recipe-defined number of seconds, counted on a 1 Hz tick from the frequency divider. The block replaces the loose state/timer glue with a single FSM, exposes the remaining seconds for a 7-segment decoder, and supports cancellation.

Parameters:
SEG_W, 4, width of the per-phase seconds counter and of seg_restantes
RINSE_SEG, 2, rinse duration in seconds; used only when CAFE_LIMPIEZA_EN is defined

Ports:
clockFPGA  input  1  system clock
reset  input  1  asynchronous, active-low reset
tick_1hz  input  1  one-clockFPGA-cycle pulse, once per second
start  input  1  one-cycle request to begin a brew; sampled only in IDLE
tipo_cafe  input  2  coffee type; captured with start
cancelar  input  1  abort request; level or pulse
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a brew completes normally
abortado  output  1  one-cycle pulse when a brew is cancelled
valvulas  output  4  one-hot valve drive: [0] agua, [1] cafe, [2] leche, [3] chocolate
fase  output  3  current state encoding (fase_t)
seg_restantes  output  SEG_W  seconds left in the current phase; 0 in IDLE

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, all counters 0, valvulas=0, busy=0, done=0, abortado=0, seg_restantes=0.
  - Valves drop immediately, with no clock required.
- Recipes, in seconds (agua, cafe, leche, choco):
  - tipo 0 espresso: 3, 2, 0, 0
  - tipo 1 americano: 6, 2, 0, 0
  - tipo 2 capuchino: 3, 2, 4, 0
  - tipo 3 mocaccino: 3, 2, 2, 3
- States: IDLE, AGUA, CAFE, LECHE, CHOCO, FIN (plus RINSE when the optional feature is enabled).
- IDLE:
  - start=1 and cancelar=0 latches tipo_cafe into tipo_q.
  - Next state is the first phase with a nonzero duration; the counter loads that duration.
  - A start arriving while busy is ignored, not queued.
- Phase states:
  - The matching valve is asserted for every cycle of the state.
  - On tick_1hz with counter>1, the counter decrements.
  - On tick_1hz with counter==1, the block moves to the next phase with a nonzero duration and loads that duration. If no such phase remains, it goes to FIN.
- Zero-duration phases are skipped inside the same transition; no cycle is spent in them.
- A tick in the same cycle as the start acceptance is ignored. The first decrement happens on the next tick.
- Phase length is N ticks, so wall time is between N−1 and N seconds. This is accepted.
- FIN: done=1 for exactly one cycle, valves off, then IDLE.
- Cancellation:
  - cancelar=1 in any phase state (or RINSE) forces IDLE on the next edge, with valves off from that edge onward.
  - abortado pulses for one cycle and done is not asserted.
  - cancelar takes priority over a simultaneous tick.
  - cancelar together with start in IDLE means no start and no abortado.
- valvulas is registered, is never more than one-hot, and is all-zero outside phase states.
- seg_restantes equals the counter in phase states and 0 in IDLE and FIN.
- The counter never wraps: a decrement from 1 is replaced by the phase transition.

Optional Feature:
- Macro CAFE_LIMPIEZA_EN.
- When defined:
  - After the last recipe phase the block enters RINSE instead of FIN.
  - RINSE asserts valvulas[0] for RINSE_SEG ticks, then goes to FIN, so done is delayed by the rinse.
  - cancelar during RINSE aborts as in any other phase.
- When undefined: the RINSE state, its logic and the RINSE_SEG usage are absent, and the last phase goes straight to FIN.

Decomposition:
- Package cafe_pkg holds:
  - typedef enum logic [2:0] fase_t (IDLE, AGUA, CAFE, LECHE, CHOCO, FIN, RINSE)
  - typedef logic [1:0] tipo_t
  - localparam recipe duration constants per type and per phase
  - valve index constants
- One sub-module, cafe_receta_rom: combinational lookup of (tipo_t, fase_t) to duration, used to pick and load the next nonzero phase.

Test Plan:
1. Reset low mid-brew in CAFE → valvulas=0 asynchronously; after release, fase=IDLE, busy=0, seg_restantes=0.
2. start with tipo 0, 10 ticks → AGUA for 3 ticks (seg 3,2,1), CAFE for 2 ticks, then FIN: done pulses exactly once, LECHE and CHOCO are never entered, and busy goes low the cycle after done.
3. start with tipo 3 → valve sequence 0001→0010→0100→1000 lasting 3, 2, 2, 3 ticks; done after the 10th tick; at most one valve bit is ever high.
4. start with tipo 2, cancelar asserted together with the 2nd LECHE tick → next cycle fase=IDLE, valvulas=0, abortado=1 for one cycle, done=0, and the tick has no effect.
5. A second start with tipo 1 during a tipo 2 brew → ignored, brew completes as tipo 2 (total 9 ticks); start and cancelar together in IDLE → stays IDLE with no pulses.
6. With CAFE_LIMPIEZA_EN and RINSE_SEG=2, tipo 0 → after CAFE, valvulas=0001 for 2 ticks, then done; without the macro, done comes directly after CAFE.
